if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 16-bit pipelined CPU. It sits directly upstream of the instruction decoder. It owns the PC, drives the instruction-memory address, and registers each fetched word into the IF/ID pipeline register that the decoder reads. It also applies hazard stalls and branch redirects, and stops fetch once a HLT opcode (4'b1111) has been fetched.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- BUBBLE_INSTR, 16'h0000, instruction word placed in IF/ID when a bubble is inserted.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  from the hazard unit; holds the PC and IF/ID.
- branch_taken  input  1  resolved taken B/BR; redirects fetch and squashes IF/ID.
- branch_target  input  16  redirect address, valid when branch_taken=1.
- imem_addr  output  16  instruction-memory address; combinational, equal to pc.
- imem_data  input  16  instruction word at imem_addr, combinational read.
- pc  output  16  current fetch PC.
- ifid_instr  output  16  registered instruction presented to the decoder.
- ifid_pc_plus2  output  16  registered fetch address + 2, used by PCS and branch target math.
- ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- halted  output  1  fetch is stopped after a HLT.

## Operation
- State machine with two states:
  - RUN: normal fetch.
  - HALTED: fetch stopped.
- Each cycle, evaluate in priority order; exactly one of the following applies:
  1. rst: pc=RESET_PC, ifid_instr=BUBBLE_INSTR, ifid_pc_plus2=0, ifid_valid=0, state=RUN.
  2. branch_taken: pc=branch_target, IF/ID=bubble (instr=BUBBLE_INSTR, valid=0, pc_plus2 unchanged), state=RUN. This applies in either state and regardless of stall.
  3. stall: pc, IF/ID and state all hold their values.
  4. HALTED: pc holds, IF/ID=bubble.
  5. RUN with imem_data[15:12]==4'b1111: IF/ID loads {imem_data, pc+2, valid=1}, pc holds, state=HALTED.
  6. RUN otherwise: IF/ID loads {imem_data, pc+2, valid=1}, pc=pc+2.
- PC arithmetic is 16-bit modulo: 16'hFFFE+2 = 16'h0000. No carry out.
- Bit 0 of branch_target is used unchanged; the block does no alignment checking.
- A HLT fetched in the same cycle as branch_taken is discarded and no halt occurs. This covers a speculative HLT in a branch shadow.
- A HLT fetched while stall=1 does not halt. It is re-fetched when the stall releases.
- halted = (state==HALTED).
- A branch_taken arriving in HALTED returns the stage to RUN, because an older branch made the HLT speculative.
- Bubbles must decode harmlessly: downstream stages gate WriteReg, MemWrite and HLT with ifid_valid.

## Timing
- Reset values:
  - pc=RESET_PC, imem_addr=RESET_PC
  - ifid_instr=BUBBLE_INSTR, ifid_pc_plus2=16'h0000, ifid_valid=0
  - halted=0
- Fetch latency is one cycle: the word at pc during cycle N appears on ifid_instr after the rising edge ending cycle N.
- Redirect: branch_taken in cycle N gives pc=branch_target and ifid_valid=0 in cycle N+1. The target instruction is valid in IF/ID in cycle N+2.
- Stall has zero-cycle effect. Outputs are unchanged on the edge where stall=1, and fetch resumes on the first edge with stall=0.
- Halt: HLT fetched in cycle N gives ifid_instr=HLT with valid=1 and halted=1 in cycle N+1. In cycle N+2 and later, ifid_valid=0 and pc stays at the HLT address.
- Reset asserted mid-operation (while stalled, halted, or in the same cycle as a branch) wins on that edge.

## Test plan
- Reset and first fetch: hold rst for 2 cycles with RESET_PC=0 and mem[0]=16'h1123 -> all outputs at their reset values. First edge after release: ifid_instr=16'h1123, ifid_pc_plus2=16'h0002, ifid_valid=1, pc=16'h0002.
- Stall: at pc=16'h0006, assert stall for 3 cycles -> pc stays 16'h0006 and IF/ID is unchanged throughout. On release: ifid_instr=mem[6], pc=16'h0008.
- Redirect beats stall: branch_taken=1 with branch_target=16'h0040 and stall=1 in the same cycle -> next cycle pc=16'h0040, ifid_valid=0. Cycle after that: ifid_instr=mem[0x40], ifid_pc_plus2=16'h0042.
- Halt: mem[0x000A]=16'hF000 -> one cycle with ifid_instr=16'hF000, valid=1, halted=1. Afterwards ifid_valid=0 and pc=16'h000A for at least 10 cycles. Then branch_taken with target 16'h0020 -> halted=0, pc=16'h0020.
- Speculative HLT: HLT at pc fetched in the same cycle as branch_taken with target 16'h0030 -> halted stays 0, pc=16'h0030, no valid F000 ever appears in IF/ID.
- Wrap-around: RESET_PC=16'hFFFE -> after one fetch, ifid_pc_plus2=16'h0000 and pc=16'h0000.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 16-bit pipelined CPU.
// Owns the PC and drives the instruction-memory address. Registers each fetched word
// into the IF/ID pipeline register. Applies hazard stalls and branch redirects, and
// stops fetching once a HLT opcode (4'b1111) has been fetched.
//
// Ports:
//   clk_i             clock, all state updates on the rising edge
//   rst_i             synchronous active-high reset
//   stall_i           hazard stall: holds PC, IF/ID and state
//   branch_taken_i    resolved taken branch: redirects fetch and squashes IF/ID
//   branch_target_i   redirect address, valid with branch_taken_i
//   imem_addr_o       instruction-memory address (combinational, equals pc_o)
//   imem_data_i       instruction word at imem_addr_o (combinational read)
//   pc_o              current fetch PC
//   ifid_instr_o      registered instruction presented to the decoder
//   ifid_pc_plus2_o   registered fetch address + 2
//   ifid_valid_o      IF/ID holds a real instruction (0 = bubble)
//   halted_o          fetch is stopped after a HLT
module if_stage #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [15:0] BUBBLE_INSTR = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [15:0] branch_target_i,
  output logic [15:0] imem_addr_o,
  input  logic [15:0] imem_data_i,
  output logic [15:0] pc_o,
  output logic [15:0] ifid_instr_o,
  output logic [15:0] ifid_pc_plus2_o,
  output logic        ifid_valid_o,
  output logic        halted_o
);

  localparam logic [3:0] OpHlt = 4'b1111;

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pp2_q, pp2_d;
  logic        valid_q, valid_d;
  logic [15:0] pc_plus2;

  // 16-bit modulo increment; the carry out is intentionally dropped.
  assign pc_plus2 = pc_q + 16'd2;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pp2_d   = pp2_q;
    valid_d = valid_q;
    if (branch_taken_i) begin
      // Redirect beats stall and un-halts: the fetched word (even a HLT) is
      // from the branch shadow and is discarded. pc_plus2 is left as is.
      pc_d    = branch_target_i;
      instr_d = BUBBLE_INSTR;
      valid_d = 1'b0;
      state_d = StRun;
    end else if (stall_i) begin
      // Everything holds; a HLT seen now is re-fetched after the stall.
      state_d = state_q;
    end else if (state_q == StHalted) begin
      instr_d = BUBBLE_INSTR;
      valid_d = 1'b0;
    end else begin
      instr_d = imem_data_i;
      pp2_d   = pc_plus2;
      valid_d = 1'b1;
      if (imem_data_i[15:12] == OpHlt) begin
        state_d = StHalted;  // pc parks on the HLT address
      end else begin
        pc_d = pc_plus2;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      instr_q <= BUBBLE_INSTR;
      pp2_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp2_q   <= pp2_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr_o     = pc_q;
  assign pc_o            = pc_q;
  assign ifid_instr_o    = instr_q;
  assign ifid_pc_plus2_o = pp2_q;
  assign ifid_valid_o    = valid_q;
  assign halted_o        = (state_q == StHalted);

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br;
  logic [15:0] tgt;
  logic [15:0] imem_addr, imem_data, pc, instr, pp2;
  logic        valid, halted;

  logic [15:0] w_addr, w_data, w_pc, w_instr, w_pp2;
  logic        w_valid, w_halted;

  logic [15:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Word-addressed model memory, indexed by byte address bits [8:1].
  assign imem_data = mem[imem_addr[8:1]];
  assign w_data    = mem[w_addr[8:1]];

  if_stage #(.RESET_PC(16'h0000), .BUBBLE_INSTR(16'h0000)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .branch_taken_i(br),
    .branch_target_i(tgt), .imem_addr_o(imem_addr), .imem_data_i(imem_data),
    .pc_o(pc), .ifid_instr_o(instr), .ifid_pc_plus2_o(pp2),
    .ifid_valid_o(valid), .halted_o(halted)
  );

  // Second instance exercises PC wrap-around from 16'hFFFE.
  if_stage #(.RESET_PC(16'hFFFE), .BUBBLE_INSTR(16'h0000)) dut_w (
    .clk_i(clk), .rst_i(rst), .stall_i(1'b0), .branch_taken_i(1'b0),
    .branch_target_i(16'h0000), .imem_addr_o(w_addr), .imem_data_i(w_data),
    .pc_o(w_pc), .ifid_instr_o(w_instr), .ifid_pc_plus2_o(w_pp2),
    .ifid_valid_o(w_valid), .halted_o(w_halted)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the whole primary-DUT state in one call.
  task automatic chk_all(input string tag, input logic [15:0] e_pc, input logic [15:0] e_instr,
                         input logic [15:0] e_pp2, input logic e_valid, input logic e_halted);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".addr"}, imem_addr, e_pc);
    chk({tag, ".instr"}, instr, e_instr);
    chk({tag, ".pp2"}, pp2, e_pp2);
    chk({tag, ".valid"}, {15'd0, valid}, {15'd0, e_valid});
    chk({tag, ".halted"}, {15'd0, halted}, {15'd0, e_halted});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h2000 + 16'(i);
    mem[0]  = 16'h1123;
    mem[5]  = 16'hF000;  // HLT at 0x000A
    mem[18] = 16'hF000;  // HLT at 0x0024 (branch shadow)

    rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = 16'h0000;
    step(); step();
    chk_all("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("reset_w.pc", w_pc, 16'hFFFE);

    // First fetch
    rst = 1'b0;
    step();
    chk_all("fetch0", 16'h0002, 16'h1123, 16'h0002, 1'b1, 1'b0);
    chk("wrap.pp2", w_pp2, 16'h0000);
    chk("wrap.pc", w_pc, 16'h0000);
    chk("wrap.instr", w_instr, 16'h20FF);
    chk("wrap.valid", {15'd0, w_valid}, 16'h0001);
    step();
    step();
    chk_all("fetch2", 16'h0006, 16'h2002, 16'h0006, 1'b1, 1'b0);

    // Stall three cycles at pc=6
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("stall", 16'h0006, 16'h2002, 16'h0006, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step();
    chk_all("unstall", 16'h0008, 16'h2003, 16'h0008, 1'b1, 1'b0);

    // Redirect beats stall
    br = 1'b1; tgt = 16'h0040; stall = 1'b1;
    step();
    chk_all("redir", 16'h0040, 16'h0000, 16'h0008, 1'b0, 1'b0);
    br = 1'b0; stall = 1'b0;
    step();
    chk_all("redir_tgt", 16'h0042, 16'h2020, 16'h0042, 1'b1, 1'b0);

    // Go to the HLT at 0x000A; a stalled HLT fetch must not halt
    br = 1'b1; tgt = 16'h000A;
    step();
    br = 1'b0; stall = 1'b1;
    step();
    chk_all("hlt_stall", 16'h000A, 16'h0000, 16'h0042, 1'b0, 1'b0);
    stall = 1'b0;
    step();
    chk_all("hlt", 16'h000A, 16'hF000, 16'h000C, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("halted", 16'h000A, 16'h0000, 16'h000C, 1'b0, 1'b1);
    end
    br = 1'b1; tgt = 16'h0020;
    step();
    chk_all("unhalt", 16'h0020, 16'h0000, 16'h000C, 1'b0, 1'b0);
    br = 1'b0;
    step();
    chk_all("unhalt_f", 16'h0022, 16'h2010, 16'h0022, 1'b1, 1'b0);
    step();
    chk_all("pre_spec", 16'h0024, 16'h2011, 16'h0024, 1'b1, 1'b0);

    // Speculative HLT at 0x0024 fetched together with a taken branch
    br = 1'b1; tgt = 16'h0030;
    step();
    chk_all("spec_hlt", 16'h0030, 16'h0000, 16'h0024, 1'b0, 1'b0);
    br = 1'b0;
    step();
    chk_all("spec_next", 16'h0032, 16'h2018, 16'h0032, 1'b1, 1'b0);

    // Reset wins over a branch while halted
    br = 1'b1; tgt = 16'h000A;
    step();
    br = 1'b0;
    step();
    chk("rehalt", {15'd0, halted}, 16'h0001);
    rst = 1'b1; br = 1'b1; tgt = 16'h0050;
    step();
    chk_all("rst_mid", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0; br = 1'b0;
    step();
    chk_all("rst_fetch", 16'h0002, 16'h1123, 16'h0002, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
